qspi_line_reader: RTL and testbench
===================================

# qspi_line_reader

Quad-I/O read engine behind the direct-mapped cache of the QSPI XIP flash controller. On a cache miss it fetches one aligned line from the SST26VF064B-class flash using the Fast Read Quad I/O command (EBh) and returns the whole line in parallel with a one-cycle `done` pulse. It owns the flash pins `sck`, `ce_n`, `din`, `dout` and `douten`. The cache/AHB front end sits directly upstream.

## Interface
Parameters:
- `LINE_SIZE`, 16: line size in bytes; legal values are 4, 8, 16, 32.
- `DUMMY_CYCLES`, 4: number of `sck` cycles between the mode byte and the first data nibble.

Ports:
- `HCLK`  in  1  system clock. There is a single clock domain.
- `HRESET`  in  1  synchronous, active-high reset.
- `req`  in  1  fetch request; sampled only in IDLE.
- `addr`  in  24  flash byte address. Bits [log2(LINE_SIZE)-1:0] are ignored and forced to 0.
- `busy`  out  1  a fetch is in progress.
- `done`  out  1  one-cycle pulse; `line` is valid in this cycle.
- `line`  out  LINE_SIZE*8  fetched line. The byte at the lowest address is in [7:0].
- `sck`  out  1  flash serial clock, at HCLK/2 while active.
- `ce_n`  out  1  flash chip enable, active low.
- `din`  in  4  SIO input from the pads.
- `dout`  out  4  SIO output to the pads.
- `douten`  out  1  output enable for all four SIO pads.

## Operation
- **States:** IDLE → CMD → ADDR → MODE → DUMMY → DATA → IDLE. Each of the five active states lasts for an integer number of `sck` cycles.
- **sck cycle shape:** each `sck` cycle is 2 HCLK cycles.
  - Low half: `sck`=0 and `dout` is updated.
  - High half: `sck`=1.
  - `din` is captured on the HCLK edge that ends the high half.
- **CMD (8 sck):** sends EBh MSB-first on SIO0. `dout`={1,1,0,bit} (WP#/HOLD# held high), `douten`=1.
- **ADDR (6 sck):** sends the 24-bit aligned address, one nibble per sck, most-significant nibble first. `douten`=1.
- **MODE (2 sck):** sends mode byte FFh (`dout`=4'hF), which prevents continuous-read mode. `douten`=1.
- **DUMMY (`DUMMY_CYCLES` sck):** `douten`=0 and `dout`=0.
- **DATA (2*LINE_SIZE sck):** `douten`=0.
  - Each byte is received high nibble first.
  - Bytes fill `line` in ascending order, starting at [7:0].
- **Line counts:**
  - Total sck cycles N = 16 + DUMMY_CYCLES + 2*LINE_SIZE.
  - A nibble counter and a byte index track the position in the phase; no widths wrap within a line.
- **Line hold:** `line` keeps its value from `done` until the next fetch overwrites it. It is not cleared at the start of a new fetch.
- **Request handling:**
  - `req` is ignored while `busy`=1 and in the cycle `done`=1.
  - `req` held high continuously starts back-to-back fetches, each separated by the minimum CE-high gap.
  - `addr` is latched at acceptance and may change freely afterwards.

## Timing
- **Reset values:** `sck`=0, `ce_n`=1, `douten`=0, `dout`=0, `busy`=0, `done`=0, `line`=0. The state machine returns to IDLE.
- **Reset in mid-fetch:** takes effect at the next HCLK edge. `ce_n` goes high immediately and no `done` is produced.
- **Cycle numbering:** cycle 0 is the cycle in which `req`=1 is sampled in IDLE. The following apply for cycles 1..2N:
  - `ce_n`=0 and `busy`=1.
  - `sck`=0 in odd cycles and 1 in even cycles.
- **Cycle 2N+1:**
  - `done`=1, `busy`=1, `ce_n`=1, `sck`=0, `douten`=0.
  - `line` is complete, including the last nibble captured at the end of cycle 2N.
- **Cycle 2N+2:** IDLE and `busy`=0.
  - The earliest next acceptance is in this cycle, giving `ce_n` high for ≥2 HCLK cycles.
- **Default latency:** N=52, so `done` is in cycle 105 and the fetch-to-fetch period is 106 cycles.
- **douten transition:** `douten` falls at the start of the first DUMMY low half. The flash does not drive before the DATA phase, so there is no bus contention.

## Test plan
- **Single fetch:** flash preloaded with byte k = k for k = 0..63; `req` with `addr`=0.
  - `done` pulses in cycle 105.
  - `line` = 128'h0F0E0D0C0B0A09080706050403020100.
  - The `ce_n` low window is exactly 104 cycles.
- **Alignment:** `req` with `addr`=24'h000013.
  - Bytes 10h..1Fh are fetched.
  - `line` = 128'h1F1E…1110.
  - ADDR nibbles on `dout` are 0,0,0,0,1,0.
- **Pin protocol:** check the fetch at `addr`=0.
  - First 8 SIO0 bits are 1,1,1,0,1,0,1,1 with `dout`[3:2]=11.
  - MODE nibbles are F,F.
  - `douten` is 1 for exactly 32 HCLK cycles.
  - `sck` shows exactly 52 rising edges.
- **Back-to-back fetches:** `req` held high with `addr`=0, then `addr`=32 while `busy`.
  - The second fetch starts in cycle 106 and returns bytes 20h..2Fh.
  - The `addr` change during the first fetch has no effect on it.
- **Reset mid-fetch:** `HRESET` pulsed high for 1 cycle at cycle 40.
  - Next cycle: `ce_n`=1, `sck`=0, `busy`=0, `line`=0, and no `done`.
  - A following fetch at `addr`=0 returns the correct line.
- **Parameter sweep:** LINE_SIZE=4, DUMMY_CYCLES=6.
  - `done` in cycle 61.
  - `line` = 32'h03020100.

Source files
------------

// File: rtl/qspi_line_reader.sv
// Quad-I/O (EBh) line fetch engine for the XIP cache: streams one aligned line
// from serial flash and presents it in parallel with a single-cycle done pulse.
module qspi_line_reader #(
    parameter int unsigned LINE_SIZE    = 16,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   req,
    input  logic [23:0]            addr,
    output logic                   busy,
    output logic                   done,
    output logic [LINE_SIZE*8-1:0] line,
    output logic                   sck,
    output logic                   ce_n,
    input  logic [3:0]             din,
    output logic [3:0]             dout,
    output logic                   douten
);

    localparam int unsigned LINE_W   = LINE_SIZE * 8;
    localparam int unsigned OFF_W    = $clog2(LINE_SIZE);
    localparam int unsigned POS_W    = OFF_W + 3;
    localparam int unsigned DATA_LEN = 2 * LINE_SIZE;
    localparam int unsigned MAX_A    = (DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8;
    localparam int unsigned MAX_LEN  = (DATA_LEN > MAX_A) ? DATA_LEN : MAX_A;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN);
    localparam logic [7:0]  CMD_BYTE = 8'hEB;
    localparam logic [23:0] ALIGN_MASK = ~24'(LINE_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               half_q, half_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [23:0]        addr_q, addr_d;
    logic               capture_c;
    logic [POS_W-1:0]   cap_pos_c;

    logic               sck_d, ce_n_d, douten_d, busy_d, done_d;
    logic [3:0]         dout_d;

    // Index of the last sck cycle in each active phase.
    function automatic logic [CNT_W-1:0] phase_last(input state_t s);
        logic [CNT_W-1:0] r;
        r = '0;
        case (s)
            S_CMD:   r = CNT_W'(7);
            S_ADDR:  r = CNT_W'(5);
            S_MODE:  r = CNT_W'(1);
            S_DUMMY: r = CNT_W'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);
            S_DATA:  r = CNT_W'(DATA_LEN - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic state_t next_phase(input state_t s);
        state_t r;
        r = S_IDLE;
        case (s)
            S_CMD:   r = S_ADDR;
            S_ADDR:  r = S_MODE;
            S_MODE:  r = (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
            S_DUMMY: r = S_DATA;
            S_DATA:  r = S_DONE;
            default: r = S_IDLE;
        endcase
        return r;
    endfunction

    // Even nibble counts land in the high half of the byte.
    assign cap_pos_c = {cnt_q[OFF_W:1], ~cnt_q[0], 2'b00};

    // Next-state sequencing plus next values of the registered pin outputs.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        capture_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_CMD;
                    half_d  = 1'b0;
                    cnt_d   = '0;
                    addr_d  = addr & ALIGN_MASK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (!half_q) begin
                    half_d = 1'b1;
                end else begin
                    half_d    = 1'b0;
                    capture_c = (state_q == S_DATA);
                    if (cnt_q == phase_last(state_q)) begin
                        state_d = next_phase(state_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        ce_n_d   = (state_d == S_IDLE) || (state_d == S_DONE);
        sck_d    = !ce_n_d && half_d;
        douten_d = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_MODE);

        // dout depends only on phase position, so it is stable across each sck cycle.
        dout_d = 4'h0;
        case (state_d)
            S_CMD:  dout_d = {3'b110, CMD_BYTE[3'd7 - cnt_d[2:0]]};
            S_ADDR: begin
                case (cnt_d[2:0])
                    3'd0:    dout_d = addr_d[23:20];
                    3'd1:    dout_d = addr_d[19:16];
                    3'd2:    dout_d = addr_d[15:12];
                    3'd3:    dout_d = addr_d[11:8];
                    3'd4:    dout_d = addr_d[7:4];
                    default: dout_d = addr_d[3:0];
                endcase
            end
            S_MODE:  dout_d = 4'hF;
            default: dout_d = 4'h0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            half_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            ce_n    <= 1'b1;
            douten  <= 1'b0;
            dout    <= 4'h0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            busy    <= busy_d;
            done    <= done_d;
            sck     <= sck_d;
            ce_n    <= ce_n_d;
            douten  <= douten_d;
            dout    <= dout_d;
        end
    end

    // Line is only overwritten nibble by nibble during DATA; it survives between fetches.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            line <= '0;
        end else if (capture_c) begin
            line[cap_pos_c +: 4] <= din;
        end
    end

endmodule

// File: tb/tb_qspi_line_reader.sv
// Bench for qspi_line_reader: two instances (default and LINE_SIZE=4/DUMMY=6)
// each attached to a behavioural quad-I/O flash that decodes what it is sent.
module tb_qspi_line_reader;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req0, req1;
    logic [23:0] addr0, addr1;
    logic        busy_v [2];
    logic        done_v [2];
    logic        sck_v [2];
    logic        ce_n_v [2];
    logic        douten_v [2];
    logic [3:0]  dout_v [2];
    logic [3:0]  din_v [2];
    logic [127:0] line0;
    logic [31:0]  line1;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] mem [256];

    // Flash/pin monitor state per channel.
    int          rcnt [2];
    int          rise_tot [2];
    int          ce_low [2];
    int          oe_cyc [2];
    int          hi_bad [2];
    int          done_cnt [2];
    int          done_at [2][4];
    logic [127:0] done_line [2][4];
    logic [7:0]  cmd_rx [2];
    logic [23:0] rx_addr [2];
    logic [7:0]  mode_rx [2];
    logic        sck_prev [2];

    qspi_line_reader u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .req(req0), .addr(addr0),
        .busy(busy_v[0]), .done(done_v[0]), .line(line0),
        .sck(sck_v[0]), .ce_n(ce_n_v[0]), .din(din_v[0]),
        .dout(dout_v[0]), .douten(douten_v[0])
    );

    qspi_line_reader #(.LINE_SIZE(4), .DUMMY_CYCLES(6)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .req(req1), .addr(addr1),
        .busy(busy_v[1]), .done(done_v[1]), .line(line1),
        .sck(sck_v[1]), .ce_n(ce_n_v[1]), .din(din_v[1]),
        .dout(dout_v[1]), .douten(douten_v[1])
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc++;

    function automatic int ls_of(input int c);
        return (c == 0) ? 16 : 4;
    endfunction
    function automatic int dummy_of(input int c);
        return (c == 0) ? 4 : 6;
    endfunction
    function automatic int n_of(input int c);
        return 16 + dummy_of(c) + 2 * ls_of(c);
    endfunction

    function automatic logic [127:0] exp_line(input logic [23:0] a, input int ls);
        logic [127:0] l;
        int base;
        l = '0;
        base = int'(a) & ~(ls - 1);
        for (int i = 0; i < ls; i++) l[8*i +: 8] = mem[(base + i) & 255];
        return l;
    endfunction

    // Flash model: decodes command/address/mode from sck rises, drives data nibbles.
    always @(negedge HCLK) begin
        for (int c = 0; c < 2; c++) begin
            int j, k;
            logic [7:0] b;
            if (!ce_n_v[c]) ce_low[c]++;
            if (douten_v[c]) oe_cyc[c]++;
            if (done_v[c]) begin
                if (done_cnt[c] < 4) begin
                    done_at[c][done_cnt[c]] = cyc;
                    done_line[c][done_cnt[c]] = (c == 0) ? line0 : 128'(line1);
                end
                done_cnt[c]++;
            end
            if (ce_n_v[c]) begin
                rcnt[c] = 0;
            end else if (sck_v[c] && !sck_prev[c]) begin
                j = rcnt[c];
                rcnt[c]++;
                rise_tot[c]++;
                if (j < 8) begin
                    cmd_rx[c] = {cmd_rx[c][6:0], dout_v[c][0]};
                    if (dout_v[c][3:2] != 2'b11) hi_bad[c]++;
                end else if (j < 14) begin
                    rx_addr[c] = {rx_addr[c][19:0], dout_v[c]};
                end else if (j < 16) begin
                    mode_rx[c] = {mode_rx[c][3:0], dout_v[c]};
                end else if (j >= 16 + dummy_of(c)) begin
                    k = j - 16 - dummy_of(c);
                    b = mem[(int'(rx_addr[c]) + k / 2) & 255];
                    din_v[c] = (k % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
            sck_prev[c] = sck_v[c];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon(input int c);
        done_cnt[c] = 0;
        ce_low[c]   = 0;
        oe_cyc[c]   = 0;
        rise_tot[c] = 0;
        hi_bad[c]   = 0;
        cmd_rx[c]   = '0;
        rx_addr[c]  = '0;
        mode_rx[c]  = '0;
    endtask

    // Raises req for exactly the acceptance cycle; t0 is that cycle's number.
    task automatic start_fetch(input int c, input logic [23:0] a, output int t0);
        @(posedge HCLK); #1;
        clear_mon(c);
        if (c == 0) begin req0 = 1'b1; addr0 = a; end
        else        begin req1 = 1'b1; addr1 = a; end
        t0 = cyc;
        @(posedge HCLK); #1;
        if (c == 0) begin req0 = 1'b0; addr0 = 24'($urandom); end
        else        begin req1 = 1'b0; addr1 = 24'($urandom); end
    endtask

    task automatic wait_done(input int c, input int n, input int budget);
        int left;
        left = budget;
        while (done_cnt[c] < n && left > 0) begin
            @(negedge HCLK);
            left--;
        end
        chk($sformatf("done_seen_ch%0d", c), 128'(done_cnt[c] >= n), 128'(1));
    endtask

    task automatic fetch_and_check(input int c, input logic [23:0] a);
        int t0, nn;
        logic [23:0] al;
        nn = n_of(c);
        al = a & ~24'(ls_of(c) - 1);
        start_fetch(c, a, t0);
        wait_done(c, 1, 400);
        repeat (3) @(negedge HCLK);
        chk("done_pulses", 128'(done_cnt[c]), 128'(1));
        chk("done_cycle", 128'(done_at[c][0] - t0), 128'(2 * nn + 1));
        chk("line", done_line[c][0], exp_line(a, ls_of(c)));
        chk("ce_low_cycles", 128'(ce_low[c]), 128'(2 * nn));
        chk("sck_rises", 128'(rise_tot[c]), 128'(nn));
        chk("douten_cycles", 128'(oe_cyc[c]), 128'(32));
        chk("cmd_byte", 128'(cmd_rx[c]), 128'(8'hEB));
        chk("cmd_hold_bits", 128'(hi_bad[c]), 128'(0));
        chk("addr_sent", 128'(rx_addr[c]), 128'(al));
        chk("mode_byte", 128'(mode_rx[c]), 128'(8'hFF));
    endtask

    initial begin
        int t0;
        for (int k = 0; k < 256; k++) mem[k] = (k < 64) ? 8'(k) : 8'($urandom);
        for (int c = 0; c < 2; c++) begin
            din_v[c] = 4'h0;
            sck_prev[c] = 1'b0;
            rcnt[c] = 0;
            clear_mon(c);
        end
        HRESET = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_ce_n", 128'(ce_n_v[0]), 128'(1));
        chk("rst_sck", 128'(sck_v[0]), 128'(0));
        chk("rst_busy_done", 128'({busy_v[0], done_v[0]}), 128'(0));
        chk("rst_pins", 128'({douten_v[0], dout_v[0]}), 128'(0));
        chk("rst_line", line0, 128'(0));
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Single fetch at 0 with known contents.
        fetch_and_check(0, 24'h000000);
        chk("line_const0", done_line[0][0], 128'h0F0E0D0C0B0A09080706050403020100);

        // Unaligned request.
        fetch_and_check(0, 24'h000013);
        chk("line_const13", done_line[0][0], 128'h1F1E1D1C1B1A19181716151413121110);

        // Line holds after done.
        repeat (5) @(negedge HCLK);
        chk("line_hold", line0, 128'h1F1E1D1C1B1A19181716151413121110);

        // Back-to-back with req held; addr changes during the first fetch.
        @(posedge HCLK); #1;
        clear_mon(0);
        req0 = 1'b1; addr0 = 24'h000000;
        t0 = cyc;
        @(posedge HCLK); #1;
        addr0 = 24'h000020;
        wait_done(0, 2, 500);
        @(posedge HCLK); #1;
        req0 = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("b2b_done0_cycle", 128'(done_at[0][0] - t0), 128'(105));
        chk("b2b_done1_cycle", 128'(done_at[0][1] - t0), 128'(211));
        chk("b2b_line0", done_line[0][0], exp_line(24'h0, 16));
        chk("b2b_line1", done_line[0][1], exp_line(24'h20, 16));
        chk("b2b_pulses", 128'(done_cnt[0]), 128'(2));

        // Reset in mid-fetch at cycle 40.
        start_fetch(0, 24'h000000, t0);
        while (cyc < t0 + 40) begin @(posedge HCLK); #1; end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("midrst_ce_n", 128'(ce_n_v[0]), 128'(1));
        chk("midrst_sck", 128'(sck_v[0]), 128'(0));
        chk("midrst_busy", 128'(busy_v[0]), 128'(0));
        chk("midrst_line", line0, 128'(0));
        repeat (150) @(negedge HCLK);
        chk("midrst_no_done", 128'(done_cnt[0]), 128'(0));
        fetch_and_check(0, 24'h000000);

        // Random addresses on the default instance.
        for (int i = 0; i < 4; i++) fetch_and_check(0, 24'($urandom));

        // Small line, longer dummy.
        fetch_and_check(1, 24'h000000);
        chk("sweep_line_const", done_line[1][0], 128'h03020100);
        for (int i = 0; i < 3; i++) fetch_and_check(1, 24'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
